spart_buffered: RTL and testbench
=================================

# spart_buffered

Parametrised next-generation serial port (SPART) for the processor I/O bus. It adds TX/RX FIFOs, a configurable frame format with optional parity, 16x-oversampled receive with mid-bit sampling, and sticky error flags. It sits between the processor's 8-bit bidirectional `databus` and the `txd`/`rxd` serial pins, and keeps the existing 4-address register map and handshake semantics.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5–8; the unused upper bits of `databus` read as 0.
- `FIFO_DEPTH`, 8: entries per FIFO, power of 2, at least 2.
- `PARITY_EN`, 0: 1 adds a parity bit after the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; only meaningful when `PARITY_EN`=1.
- `DB_RESET`, 16'd162: divisor value loaded at reset.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `iocs`  in  1  chip select.
- `iorw`  in  1  1 = read (SPART drives the bus), 0 = write.
- `ioaddr`  in  2  00 data, 01 status/control, 10 DB low, 11 DB high.
- `databus`  inout  8  processor data bus.
- `rda`  out  1  RX FIFO not empty.
- `tbr`  out  1  TX FIFO not full.
- `txd`  out  1  serial out; idles at 1.
- `rxd`  in  1  serial in; asynchronous.

## Operation
- **Access rule:** an access occurs only when `iocs`=1. Each cycle with `iocs` asserted counts as one access, so the processor strobes for exactly one cycle.
- **Write 00:** pushes `databus[DATA_BITS-1:0]` into the TX FIFO. Ignored when the FIFO is full; no error is flagged.
- **Read 00:** drives the RX FIFO head onto the bus and pops it in the same cycle. When the FIFO is empty it returns 0 and pops nothing.
- **Read 01:** returns `{frame_err, parity_err, overrun, rx_full, tx_empty, 1'b0, rda, tbr}`.
- **Write 01:** any write clears the three sticky error flags.
- **Read/write 10/11:** access DB[7:0] and DB[15:8] respectively.
- **Bus drive:** the bus is driven only while `iocs`&&`iorw`; otherwise it is high-Z.
- **Baud tick:** a 16-bit down-counter reloads from DB and emits a 1-cycle `tick16` on reaching 0, i.e. every DB+1 cycles.
  - DB=0 gives a tick every cycle.
  - A DB write takes effect at the next reload; the counter is never restarted mid-period.
- **TX FSM** (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`), each state 16 ticks long:
  - Leaves `IDLE` on the first `tick16` with the TX FIFO non-empty, popping the head into the shift register.
  - Data is sent LSB first.
  - `PARITY` is skipped when `PARITY_EN`=0.
  - After `STOP`, goes back-to-back into `START` if the FIFO is non-empty, otherwise returns to `IDLE`.
- **RX path:**
  - `rxd` passes through a 2-flop synchroniser.
  - **RX FSM** (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`):
    - A falling edge in `IDLE` starts a 0–15 oversample count.
    - At count 7 of `START`, a 1 on the line is a false start and returns the FSM to `IDLE`.
    - After the start check, the line is sampled every 16 ticks.
  - At `STOP`:
    - A stop bit of 0 sets `frame_err` and discards the byte.
    - A parity mismatch sets `parity_err` and discards the byte.
    - Otherwise the byte is pushed into the RX FIFO; if the FIFO is full, the byte is dropped and `overrun` is set.
  - The FSM returns to `IDLE` immediately after the stop sample.
- **FIFOs:** a push and a pop in the same cycle both take effect and the count is unchanged. Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally; the count is one bit wider.

## Timing
- **Reset values:**
  - `txd`=1, `tbr`=1, `rda`=0, `databus`=Z.
  - FIFOs empty, error flags 0, DB=`DB_RESET`, both FSMs in `IDLE`.
- **Reset mid-frame:** aborts immediately and `txd` returns to 1 asynchronously.
- **Flag timing:** `rda` rises the cycle after the RX push; `tbr` updates the cycle after a push or pop.
- **Read data:** combinational from the current FIFO head, valid in the access cycle.
- **Frame length:** (1 + `DATA_BITS` + `PARITY_EN` + 1) × 16 × (DB+1) cycles.
- **TX start latency:** the first start bit appears at most 16·(DB+1)+1 cycles after a push into an empty, idle TX path.
- **RX push point:** the byte is pushed on the cycle of the stop-bit sample, i.e. roughly mid-stop bit.

## Structure
- **`spart_pkg`:** register address constants, status bit indices, TX/RX state enums, and a parity function.
- **Sub-module `spart_sync_fifo`:** parametrised width and depth, with push, pop, full, empty and count ports; instantiated twice.
- **Top level:** baud generator, both FSMs, synchroniser and bus decode live in `spart_buffered`.

## Test plan
- **Basic loopback:** DB=0, `txd` looped to `rxd`, write 0xA5 then 0x3C. Expect `rda`=1, reads return 0xA5 then 0x3C, and `rda`=0 after that.
- **TX FIFO fill:** 9 writes at `FIFO_DEPTH`=8 with TX stalled by DB=16'hFFFF. Expect `tbr`=0 after the 8th write, the 9th write ignored, and `tx_empty`=0.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, inject a frame for 0x07 with parity bit 0. Expect `parity_err`=1 and RX FIFO empty; a write to 01 clears the flag.
- **Framing and false start:** stop bit forced to 0 gives `frame_err`=1. A 3-tick low glitch on `rxd` pushes nothing and the RX FSM returns to `IDLE`.
- **Overrun:** inject 9 frames without reading. Expect 8 bytes retained in order and `overrun`=1.
- **Reset mid-transmit:** deassert `rst` during the DATA bits. Expect `txd`=1, `tbr`=1, `rda`=0 immediately and DB=`DB_RESET`.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the buffered SPART: register map, status bit positions,
// serial FSM state encodings and the frame parity helper.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int ST_TBR        = 0;
    localparam int ST_RDA        = 1;
    localparam int ST_TX_EMPTY   = 3;
    localparam int ST_RX_FULL    = 4;
    localparam int ST_OVERRUN    = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_FRAME_ERR  = 7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1);
    // callers zero-extend narrower payloads, which leaves the result unchanged.
    function automatic logic parityBit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with a one-bit-wider occupancy count; pushes into a full FIFO
// are dropped unless a pop happens in the same cycle, pops of an empty FIFO do nothing.
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPop  = i_pop && (r_count != '0);
    assign w_doPush = i_push && ((r_count != FULL_COUNT) || w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/spart_buffered.sv
// Buffered serial port: bus register decode, baud generator, TX/RX FIFOs and the
// 16x-oversampled transmit and receive state machines.
module spart_buffered
    import spart_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PARITY_EN  = 0,
    parameter int          PARITY_ODD = 0,
    parameter logic [15:0] DB_RESET   = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int          CW         = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] FULL_COUNT = FIFO_DEPTH[CW:0];
    localparam int          LB         = DATA_BITS - 1;
    localparam logic [2:0]  LAST_BIT   = LB[2:0];
    localparam logic        ODD_SEL    = (PARITY_ODD != 0);

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_txPush;
    logic                 w_rxPop;
    logic                 w_errClear;
    logic [15:0]          r_db;
    logic [15:0]          r_baudCnt;
    logic                 w_tick;
    logic [7:0]           w_rdData;
    logic [7:0]           w_status;

    logic [DATA_BITS-1:0] w_txHead;
    logic                 w_txFull;
    logic                 w_txEmpty;
    logic [CW:0]          w_txCount;
    logic                 w_txPop;
    tx_state_t            r_txState;
    tx_state_t            w_txNext;
    logic [3:0]           r_txTick;
    logic [2:0]           r_txBit;
    logic [DATA_BITS-1:0] r_txShift;
    logic                 r_txPar;
    logic                 w_txBitDone;

    logic [DATA_BITS-1:0] w_rxHead;
    logic                 w_rxFull;
    logic                 w_rxEmpty;
    logic [CW:0]          w_rxCount;
    logic                 w_rxPush;
    logic                 r_rxSync1;
    logic                 r_rxSync2;
    logic                 r_rxPrev;
    logic                 w_rxFall;
    rx_state_t            r_rxState;
    rx_state_t            w_rxNext;
    logic [3:0]           r_rxTick;
    logic [2:0]           r_rxBit;
    logic [DATA_BITS-1:0] r_rxShift;
    logic                 r_rxParBit;
    logic                 w_rxMid;
    logic                 w_rxEnd;
    logic                 w_rxStopSample;
    logic                 w_rxParOk;
    logic                 r_frameErr;
    logic                 r_parityErr;
    logic                 r_overrun;

    assign w_wr       = iocs && !iorw;
    assign w_rd       = iocs && iorw;
    assign w_txPush   = w_wr && (ioaddr == ADDR_DATA);
    assign w_rxPop    = w_rd && (ioaddr == ADDR_DATA);
    assign w_errClear = w_wr && (ioaddr == ADDR_STATUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db <= DB_RESET;
        end else if (w_wr && (ioaddr == ADDR_DB_LO)) begin
            r_db[7:0] <= databus;
        end else if (w_wr && (ioaddr == ADDR_DB_HI)) begin
            r_db[15:8] <= databus;
        end
    end

    // The divisor is only sampled on reload, so a DB write never cuts a period short.
    assign w_tick = (r_baudCnt == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baudCnt <= DB_RESET;
        end else if (w_tick) begin
            r_baudCnt <= r_db;
        end else begin
            r_baudCnt <= r_baudCnt - 16'd1;
        end
    end

    spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_txPush),
        .i_pop   (w_txPop),
        .i_data  (databus[DATA_BITS-1:0]),
        .o_data  (w_txHead),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty),
        .o_count (w_txCount)
    );

    spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rxPush),
        .i_pop   (w_rxPop),
        .i_data  (r_rxShift),
        .o_data  (w_rxHead),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty),
        .o_count (w_rxCount)
    );

    assign w_txBitDone = w_tick && (r_txTick == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txState <= TX_IDLE;
        end else begin
            r_txState <= w_txNext;
        end
    end

    // txd is decoded from the state register so an async reset forces the line idle at once.
    always_comb begin
        w_txNext = r_txState;
        w_txPop  = 1'b0;
        txd      = 1'b1;
        case (r_txState)
            TX_IDLE: begin
                if (w_tick && !w_txEmpty) begin
                    w_txNext = TX_START;
                    w_txPop  = 1'b1;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (w_txBitDone) begin
                    w_txNext = TX_DATA;
                end
            end
            TX_DATA: begin
                txd = r_txShift[0];
                if (w_txBitDone && (r_txBit == LAST_BIT)) begin
                    w_txNext = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                txd = r_txPar;
                if (w_txBitDone) begin
                    w_txNext = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_txBitDone) begin
                    if (!w_txEmpty) begin
                        w_txNext = TX_START;
                        w_txPop  = 1'b1;
                    end else begin
                        w_txNext = TX_IDLE;
                    end
                end
            end
            default: w_txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txTick  <= 4'd0;
            r_txBit   <= 3'd0;
            r_txShift <= '0;
            r_txPar   <= 1'b0;
        end else if (w_txPop) begin
            r_txShift <= w_txHead;
            r_txPar   <= parityBit(8'(w_txHead), ODD_SEL);
            r_txTick  <= 4'd0;
            r_txBit   <= 3'd0;
        end else if ((r_txState != TX_IDLE) && w_tick) begin
            r_txTick <= r_txTick + 1'b1;
            if (w_txBitDone && (r_txState == TX_DATA)) begin
                r_txShift <= r_txShift >> 1;
                r_txBit   <= r_txBit + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_rxFall = r_rxPrev && !r_rxSync2;
    assign w_rxMid  = w_tick && (r_rxTick == 4'd7);
    assign w_rxEnd  = w_tick && (r_rxTick == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxNext;
        end
    end

    // Every bit is sampled at oversample count 7; the stop bit ends the frame right there.
    always_comb begin
        w_rxNext       = r_rxState;
        w_rxStopSample = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (w_rxFall) begin
                    w_rxNext = RX_START;
                end
            end
            RX_START: begin
                if (w_rxMid && r_rxSync2) begin
                    w_rxNext = RX_IDLE;
                end else if (w_rxEnd) begin
                    w_rxNext = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rxEnd && (r_rxBit == LAST_BIT)) begin
                    w_rxNext = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rxEnd) begin
                    w_rxNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rxMid) begin
                    w_rxStopSample = 1'b1;
                    w_rxNext       = RX_IDLE;
                end
            end
            default: w_rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxTick   <= 4'd0;
            r_rxBit    <= 3'd0;
            r_rxShift  <= '0;
            r_rxParBit <= 1'b0;
        end else if (r_rxState == RX_IDLE) begin
            r_rxTick <= 4'd0;
            r_rxBit  <= 3'd0;
        end else if (w_tick) begin
            r_rxTick <= r_rxTick + 1'b1;
            if (w_rxMid && (r_rxState == RX_DATA)) begin
                r_rxShift <= {r_rxSync2, r_rxShift[DATA_BITS-1:1]};
            end
            if (w_rxMid && (r_rxState == RX_PARITY)) begin
                r_rxParBit <= r_rxSync2;
            end
            if (w_rxEnd && (r_rxState == RX_DATA)) begin
                r_rxBit <= r_rxBit + 1'b1;
            end
        end
    end

    assign w_rxParOk = (PARITY_EN == 0) ||
                       (r_rxParBit == parityBit(8'(r_rxShift), ODD_SEL));
    assign w_rxPush  = w_rxStopSample && r_rxSync2 && w_rxParOk;

    // A same-cycle set wins over a clear so no error event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_errClear) begin
                r_frameErr  <= 1'b0;
                r_parityErr <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_rxStopSample && !r_rxSync2) begin
                r_frameErr <= 1'b1;
            end
            if (w_rxStopSample && r_rxSync2 && !w_rxParOk) begin
                r_parityErr <= 1'b1;
            end
            if (w_rxPush && w_rxFull && !w_rxPop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rda = !w_rxEmpty;
    assign tbr = !w_txFull;

    always_comb begin
        w_status                = 8'h00;
        w_status[ST_TBR]        = tbr;
        w_status[ST_RDA]        = rda;
        w_status[ST_TX_EMPTY]   = (w_txCount == '0);
        w_status[ST_RX_FULL]    = (w_rxCount == FULL_COUNT);
        w_status[ST_OVERRUN]    = r_overrun;
        w_status[ST_PARITY_ERR] = r_parityErr;
        w_status[ST_FRAME_ERR]  = r_frameErr;
    end

    always_comb begin
        w_rdData = 8'h00;
        case (ioaddr)
            ADDR_DATA:   w_rdData = w_rxEmpty ? 8'h00 : 8'(w_rxHead);
            ADDR_STATUS: w_rdData = w_status;
            ADDR_DB_LO:  w_rdData = r_db[7:0];
            ADDR_DB_HI:  w_rdData = r_db[15:8];
            default:     w_rdData = 8'h00;
        endcase
    end

    assign databus = (iocs && iorw) ? w_rdData : 8'bz;

endmodule

// File: tb/tb_spart_buffered.sv
// Randomised scoreboard bench for spart_buffered (even parity enabled): bus reads of
// the data register are checked against a queue filled by a frame-level reference model.
module tb_spart_buffered;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    wire        rxd;

    logic [7:0] tbBus = 8'h00;
    logic       tbDrive = 1'b0;
    logic       loopback = 1'b0;
    logic       rxdDrv = 1'b1;

    int         tests = 0;
    int         failures = 0;
    logic [7:0] expQ[$];
    logic [7:0] txModel[$];
    logic [7:0] monExp;
    logic       expFrame = 1'b0;
    logic       expParity = 1'b0;
    logic       expOverrun = 1'b0;
    logic [7:0] rdVal;
    logic [7:0] b;

    assign databus = tbDrive ? tbBus : 8'bz;
    assign rxd     = loopback ? txd : rxdDrv;

    always #5 clk = ~clk;

    spart_buffered #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .DB_RESET   (16'd162)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every data-register read pops the next byte the model says is buffered.
    always @(negedge clk) begin
        if (rst && iocs && iorw && (ioaddr == 2'b00)) begin
            monExp = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
            checkOutput("rx data read", {8'h00, databus}, {8'h00, monExp});
        end
    end

    function automatic logic evenPar(input logic [7:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    // Frame-level receive rules: stop error, then parity error, then buffer or overrun.
    function automatic void modelFrame(input logic [7:0] v, input logic par, input logic stop);
        if (!stop) begin
            expFrame = 1'b1;
        end else if (par != evenPar(v)) begin
            expParity = 1'b1;
        end else if (expQ.size() < DEPTH) begin
            expQ.push_back(v);
        end else begin
            expOverrun = 1'b1;
        end
    endfunction

    function automatic logic [7:0] modelStatus(input logic txEmpty, input logic txNotFull);
        return {expFrame, expParity, expOverrun, expQ.size() == DEPTH,
                txEmpty, 1'b0, expQ.size() != 0, txNotFull};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tbBus = d; tbDrive = 1'b1;
        @(posedge clk); #2;
        iocs = 1'b0; tbDrive = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #2;
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk);
        d = databus;
        @(posedge clk); #2;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic clearErrors();
        busWrite(2'b01, 8'h00);
        expFrame = 1'b0; expParity = 1'b0; expOverrun = 1'b0;
    endtask

    task automatic driveBit(input logic v);
        @(posedge clk); #2;
        rxdDrv = v;
        repeat (15) @(posedge clk);
    endtask

    // Injects one frame at DB=0 (16 clocks per bit): start, 8 data LSB first, parity, stop.
    task automatic applyStimulus(input logic [7:0] v, input logic par, input logic stop);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(v[i]);
        driveBit(par);
        driveBit(stop);
        @(posedge clk); #2;
        rxdDrv = 1'b1;
        waitCycles(4);
    endtask

    initial begin
        waitCycles(3); #1;
        checkOutput("reset txd", {15'h0, txd}, 16'h1);
        checkOutput("reset tbr", {15'h0, tbr}, 16'h1);
        checkOutput("reset rda", {15'h0, rda}, 16'h0);
        @(posedge clk); #2 rst = 1'b1;
        busRead(2'b10, rdVal); checkOutput("db low after reset", {8'h0, rdVal}, 16'h00A2);
        busRead(2'b11, rdVal); checkOutput("db high after reset", {8'h0, rdVal}, 16'h0000);
        busRead(2'b01, rdVal); checkOutput("status after reset", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});

        busWrite(2'b11, 8'h00);
        busWrite(2'b10, 8'h00);
        loopback = 1'b1;
        busWrite(2'b00, 8'hA5); modelFrame(8'hA5, evenPar(8'hA5), 1'b1);
        busWrite(2'b00, 8'h3C); modelFrame(8'h3C, evenPar(8'h3C), 1'b1);
        waitCycles(700);
        @(negedge clk);
        checkOutput("rda after loopback", {15'h0, rda}, 16'h1);
        busRead(2'b00, rdVal);
        busRead(2'b00, rdVal);
        @(negedge clk);
        checkOutput("rda after draining", {15'h0, rda}, 16'h0);
        busRead(2'b00, rdVal);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            busWrite(2'b00, b);
            modelFrame(b, evenPar(b), 1'b1);
        end
        waitCycles(900);
        busRead(2'b01, rdVal); checkOutput("status random loopback", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        for (int i = 0; i < 4; i++) busRead(2'b00, rdVal);

        busWrite(2'b11, 8'hFF);
        busWrite(2'b10, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            busWrite(2'b00, b);
            if (txModel.size() < DEPTH) txModel.push_back(b);
            if (i == 7) begin
                @(negedge clk);
                checkOutput("tbr after 8 writes", {15'h0, tbr}, 16'h0);
            end
        end
        busRead(2'b01, rdVal); checkOutput("status tx full", {8'h0, rdVal}, {8'h0, modelStatus(1'b0, 1'b0)});
        busWrite(2'b10, 8'h00);
        busWrite(2'b11, 8'h00);
        waitCycles(65536 + 8 * 176 + 300);
        foreach (txModel[i]) modelFrame(txModel[i], evenPar(txModel[i]), 1'b1);
        txModel.delete();
        busRead(2'b01, rdVal); checkOutput("status after tx drain", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        for (int i = 0; i < 9; i++) busRead(2'b00, rdVal);
        loopback = 1'b0;

        applyStimulus(8'h07, 1'b0, 1'b1); modelFrame(8'h07, 1'b0, 1'b1);
        busRead(2'b01, rdVal); checkOutput("status parity error", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        clearErrors();
        busRead(2'b01, rdVal); checkOutput("status parity cleared", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        applyStimulus(8'h07, 1'b1, 1'b1); modelFrame(8'h07, 1'b1, 1'b1);
        busRead(2'b00, rdVal);

        applyStimulus(8'h55, evenPar(8'h55), 1'b0); modelFrame(8'h55, evenPar(8'h55), 1'b0);
        busRead(2'b01, rdVal); checkOutput("status frame error", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        clearErrors();
        @(posedge clk); #2 rxdDrv = 1'b0;
        repeat (3) @(posedge clk);
        #2 rxdDrv = 1'b1;
        waitCycles(40);
        busRead(2'b01, rdVal); checkOutput("status after glitch", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        b = 8'($urandom);
        applyStimulus(b, evenPar(b), 1'b1); modelFrame(b, evenPar(b), 1'b1);
        busRead(2'b00, rdVal);

        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            applyStimulus(b, evenPar(b), 1'b1);
            modelFrame(b, evenPar(b), 1'b1);
        end
        busRead(2'b01, rdVal); checkOutput("status overrun", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});
        for (int i = 0; i < 9; i++) busRead(2'b00, rdVal);
        clearErrors();

        b = 8'($urandom);
        applyStimulus(b, evenPar(b), 1'b1); modelFrame(b, evenPar(b), 1'b1);
        @(negedge clk);
        checkOutput("rda before reset", {15'h0, rda}, 16'h1);
        busWrite(2'b00, 8'h00);
        waitCycles(40);
        @(negedge clk);
        checkOutput("txd during data bits", {15'h0, txd}, 16'h0);
        #1 rst = 1'b0;
        #1;
        checkOutput("txd on mid-frame reset", {15'h0, txd}, 16'h1);
        checkOutput("tbr on mid-frame reset", {15'h0, tbr}, 16'h1);
        checkOutput("rda on mid-frame reset", {15'h0, rda}, 16'h0);
        expQ.delete();
        expFrame = 1'b0; expParity = 1'b0; expOverrun = 1'b0;
        waitCycles(2);
        #2 rst = 1'b1;
        busRead(2'b10, rdVal); checkOutput("db low after mid reset", {8'h0, rdVal}, 16'h00A2);
        busRead(2'b11, rdVal); checkOutput("db high after mid reset", {8'h0, rdVal}, 16'h0000);
        busRead(2'b01, rdVal); checkOutput("status after mid reset", {8'h0, rdVal}, {8'h0, modelStatus(1'b1, 1'b1)});

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
